// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and helpers for the fetch branch predictor.
// Counter constants are functions so each user can size them to its own CTR_BITS.
package bp_pkg;

    function automatic int idxWidth(input int entries);
        return $clog2(entries);
    endfunction

    function automatic logic [31:0] ctrWeakTaken(input int bits);
        return 32'(1) << (bits - 1);
    endfunction

    function automatic logic [31:0] ctrMax(input int bits);
        return (32'(1) << bits) - 32'(1);
    endfunction

    function automatic logic [31:0] ctrMin(input int bits);
        return (bits > 0) ? 32'(0) : 32'(0);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: next-value logic for an up/down saturating direction counter (no state).
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                up,
    output logic [CTR_BITS-1:0] nxt
);
    localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctrMax(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MIN = CTR_BITS'(ctrMin(CTR_BITS));

    always_comb begin
        nxt = up ? ((ctr == CTR_MAX) ? ctr : ctr + 1'b1)
                 : ((ctr == CTR_MIN) ? ctr : ctr - 1'b1);
    end
endmodule

// File: rtl/fetch_bpred_unit.sv
// fetch_bpred_unit: fetch PC generator with a direct-mapped BTB and saturating-counter
// direction predictor; E-stage resolution drives BTB updates and mispredict redirects.
module fetch_bpred_unit
    import bp_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter int              CTR_BITS    = 2,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_f,
    output logic [XLEN-1:0]   pc_f,
    output logic              pred_taken_f,
    output logic [XLEN-1:0]   pred_target_f,
    input  logic              ex_valid,
    input  logic              ex_is_cf,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              mispredict_e,
    output logic [PERF_W-1:0] perf_cf_cnt,
    output logic [PERF_W-1:0] perf_mp_cnt
);
    localparam int IDXW = idxWidth(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(ctrWeakTaken(CTR_BITS));

    logic [TAGW-1:0]     tagArr [BTB_ENTRIES];
    logic [XLEN-1:0]     tgtArr [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctrArr [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] valid;

    logic [IDXW-1:0]     fIdx, eIdx;
    logic [TAGW-1:0]     fTag, eTag;
    logic                fHit, eHit;
    logic [CTR_BITS-1:0] ctrNext;
    logic [XLEN-1:0]     pcNext;

    assign fIdx = pc_f[IDXW+1:2];
    assign fTag = pc_f[XLEN-1:IDXW+2];
    assign eIdx = ex_pc[IDXW+1:2];
    assign eTag = ex_pc[XLEN-1:IDXW+2];
    assign fHit = valid[fIdx] & (tagArr[fIdx] == fTag);
    assign eHit = valid[eIdx] & (tagArr[eIdx] == eTag);

    assign pred_taken_f  = fHit & ctrArr[fIdx][CTR_BITS-1];
    assign pred_target_f = tgtArr[fIdx];

    assign mispredict_e = ex_valid & (
        (ex_is_cf & ((ex_pred_taken != ex_taken) | (ex_taken & (ex_pred_target != ex_target))))
        | (~ex_is_cf & ex_pred_taken));

    bp_sat_ctr #(.CTR_BITS(CTR_BITS)) uCtr (
        .ctr(ctrArr[eIdx]),
        .up (ex_taken),
        .nxt(ctrNext)
    );

    always_comb begin
        pcNext = mispredict_e ? ((ex_taken & ex_is_cf) ? ex_target : ex_pc + XLEN'(4))
               : stall_f      ? pc_f
               : pred_taken_f ? pred_target_f
               :                pc_f + XLEN'(4);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f        <= RESET_PC;
            valid       <= '0;
            perf_cf_cnt <= '0;
            perf_mp_cnt <= '0;
        end else begin
            pc_f        <= pcNext;
            perf_cf_cnt <= perf_cf_cnt + PERF_W'(ex_valid & ex_is_cf);
            perf_mp_cnt <= perf_mp_cnt + PERF_W'(mispredict_e);
            if (ex_valid & ex_is_cf & ex_taken & ~eHit)
                valid[eIdx] <= 1'b1;
            else if (ex_valid & ~ex_is_cf & eHit)
                valid[eIdx] <= 1'b0;
        end
    end

    // Payload arrays are unreset; writes are blocked while reset is held so pending E inputs are dropped.
    always_ff @(posedge clk) begin
        if (reset & ex_valid & ex_is_cf) begin
            if (!eHit) begin
                if (ex_taken) begin
                    tagArr[eIdx] <= eTag;
                    tgtArr[eIdx] <= ex_target;
                    ctrArr[eIdx] <= CTR_WEAK;
                end
            end else begin
                if (ex_taken)
                    tgtArr[eIdx] <= ex_target;
                ctrArr[eIdx] <= ctrNext;
            end
        end
    end
endmodule
